// File: rtl/alu_mul_seq_pkg.sv
// Shared definitions for the sequential shift-add multiplier: state encodings,
// iteration count and the ALU opcode that selects this unit.
package alu_mul_seq_pkg;

   localparam int MUL_ITERATIONS = 32;
   localparam int MUL_CNT_W      = $clog2(MUL_ITERATIONS);

   // Opcode the surrounding ALU decoder uses to route work to this unit
   localparam logic [3:0] ALU_OP_MUL = 4'b1010;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } mul_state_e;

endpackage

// File: rtl/alu_mul_seq_mul_step.sv
// One combinational add-and-shift iteration of the multiplier (module mul_step).
module mul_step #(
   parameter int XLEN = 32
) (
   input  logic [XLEN-1:0] acc_i,
   input  logic [XLEN-1:0] mcand_i,
   input  logic [XLEN-1:0] mplier_i,
   output logic [XLEN-1:0] acc_o,
   output logic [XLEN-1:0] mcand_o,
   output logic [XLEN-1:0] mplier_o
);

   always_comb begin
      acc_o    = mplier_i[0] ? (acc_i + mcand_i) : acc_i;
      mcand_o  = {mcand_i[XLEN-2:0], 1'b0};
      mplier_o = {1'b0, mplier_i[XLEN-1:1]};
   end

endmodule

// File: rtl/alu_mul_seq.sv
// Sequential 32x32 -> low-32 shift-add multiplier with valid/ready handshakes.
// Optional macro MUL_EARLY_EXIT_EN: finish as soon as the multiplier reg is zero.
//
//   state  | meaning
//   S_IDLE | waiting for operands, start_ready=1
//   S_RUN  | one add-and-shift iteration per cycle
//   S_DONE | product on w, waiting for result_ready
module alu_mul_seq
   import alu_mul_seq_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            kill,
   input  logic            start_valid,
   output logic            start_ready,
   input  logic [XLEN-1:0] x,
   input  logic [XLEN-1:0] y,
   output logic            result_valid,
   input  logic            result_ready,
   output logic [XLEN-1:0] w,
   output logic            busy
);

   mul_state_e           state_q, state_d;
   logic [XLEN-1:0]      acc_q, acc_d;
   logic [XLEN-1:0]      mcand_q, mcand_d;
   logic [XLEN-1:0]      mplier_q, mplier_d;
   logic [MUL_CNT_W-1:0] cnt_q, cnt_d;

   logic [XLEN-1:0]      step_acc, step_mcand, step_mplier;
   logic                 early_done;

   mul_step #(.XLEN(XLEN)) u_step (
      .acc_i    (acc_q),
      .mcand_i  (mcand_q),
      .mplier_i (mplier_q),
      .acc_o    (step_acc),
      .mcand_o  (step_mcand),
      .mplier_o (step_mplier)
   );

`ifdef MUL_EARLY_EXIT_EN
   assign early_done = (step_mplier == '0);
`else
   assign early_done = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= S_IDLE;
         acc_q    <= '0;
         mcand_q  <= '0;
         mplier_q <= '0;
         cnt_q    <= '0;
      end else begin
         state_q  <= state_d;
         acc_q    <= acc_d;
         mcand_q  <= mcand_d;
         mplier_q <= mplier_d;
         cnt_q    <= cnt_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      acc_d    = acc_q;
      mcand_d  = mcand_q;
      mplier_d = mplier_q;
      cnt_d    = cnt_q;
      case (state_q)
         S_IDLE: begin
            if (start_valid) begin
               acc_d    = '0;
               mcand_d  = x;
               mplier_d = y;
               cnt_d    = '0;
               state_d  = S_RUN;
            end
         end
         S_RUN: begin
            acc_d    = step_acc;
            mcand_d  = step_mcand;
            mplier_d = step_mplier;
            cnt_d    = cnt_q + 1'b1;
            if ((cnt_q == MUL_CNT_W'(MUL_ITERATIONS - 1)) || early_done) begin
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            if (result_ready) begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
      // Flush wins over accept and over result consumption
      if (kill) begin
         state_d = S_IDLE;
      end
   end

   assign start_ready  = (state_q == S_IDLE);
   assign result_valid = (state_q == S_DONE);
   assign busy         = (state_q == S_RUN) || (state_q == S_DONE);
   assign w            = result_valid ? acc_q : '0;

endmodule

// File: doc/alu_mul_seq.md
ALU_MUL_SEQ -- requirements
Module: alu_mul_seq

Interface
REQ-001 SHALL have parameter XLEN, default 32, meaning operand/result width; only 32 is supported.
REQ-002 SHALL have port clk  input  1  sole clock, all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port kill  input  1  pipeline flush; aborts any operation in flight.
REQ-005 SHALL have port start_valid  input  1  requester presents operands.
REQ-006 SHALL have port start_ready  output  1  unit can accept operands.
REQ-007 SHALL have port x  input  32  multiplicand, sampled only on accept.
REQ-008 SHALL have port y  input  32  multiplier, sampled only on accept.
REQ-009 SHALL have port result_valid  output  1  w holds a finished product.
REQ-010 SHALL have port result_ready  input  1  consumer takes result.
REQ-011 SHALL have port w  output  32  product, low 32 bits of x*y.
REQ-012 SHALL have port busy  output  1  high in RUN or DONE; used as pipeline stall.

Function
REQ-013 SHALL implement FSM states IDLE, RUN, DONE.
REQ-014 SHALL drive start_ready=1 only in IDLE; accept = start_valid && start_ready.
REQ-015 SHALL on accept latch x into multiplicand reg, y into multiplier reg, clear accumulator and iteration counter, go to RUN.
REQ-016 SHALL per RUN cycle: if multiplier bit0=1, add multiplicand to accumulator (mod 2^32); shift multiplicand left 1, multiplier right 1 (logical); increment counter.
REQ-017 SHALL leave RUN for DONE after the 32nd RUN cycle (counter wraps 31->0).
REQ-018 SHALL produce w equal bit-for-bit to the low 32 bits of signed(x)*signed(y) (identical to unsigned low half); no overflow or exception signalling.
REQ-019 SHALL give latency: accept at edge k, RUN during cycles k+1..k+32, result_valid=1 from cycle k+33.
REQ-020 SHALL hold result_valid=1 and w stable in DONE until result_ready=1; then go IDLE next edge.
REQ-021 SHALL not accept a new operation in the DONE->IDLE cycle; earliest next accept is first cycle in IDLE.
REQ-022 SHALL drive w=0 whenever result_valid=0.
REQ-023 SHALL on kill=1 (any state) go IDLE next edge, discard result; kill has priority over accept and over result_ready.
REQ-024 SHALL ignore x, y, start_valid changes while not in IDLE.

Reset
REQ-025 SHALL on reset=1 at a rising edge enter IDLE, clear accumulator, operand regs and counter; reset overrides kill and all handshakes, including mid-RUN.
REQ-026 SHALL present after reset: start_ready=1, result_valid=0, w=0, busy=0.

Configuration
REQ-027 SHALL honour macro MUL_EARLY_EXIT_EN.
REQ-028 SHALL with MUL_EARLY_EXIT_EN defined leave RUN for DONE at the end of any RUN cycle whose post-shift multiplier reg is zero; iterations n = max(1, index of highest set bit of y + 1), result_valid from cycle k+1+n.
REQ-029 SHALL without MUL_EARLY_EXIT_EN always run exactly 32 iterations (REQ-019); product value identical in both builds.

Structure
REQ-030 SHALL place FSM state encodings, MUL_ITERATIONS=32 and the ALU_OP_MUL opcode reference in the shared definitions file.
REQ-031 SHALL isolate one add-and-shift step in sub-module mul_step (combinational: acc, mcand, mplier in; next acc, mcand, mplier out).
REQ-032 SHALL keep all sequential state in alu_mul_seq.

Verification
REQ-033 SHALL cover: reset, then x=7, y=6 accepted at k -> result_valid rises at k+33, w=42; no early exit.
REQ-034 SHALL cover: x=0xFFFFFFFD (-3), y=5 -> w=0xFFFFFFF1 (-15); with MUL_EARLY_EXIT_EN result_valid at k+4.
REQ-035 SHALL cover: x=0x80000000, y=0xFFFFFFFF -> w=0x80000000; 32 iterations in both builds.
REQ-036 SHALL cover: result_ready held 0 for 10 cycles in DONE -> result_valid and w stable, start_ready=0, busy=1; ready=1 -> IDLE next edge.
REQ-037 SHALL cover: kill asserted at k+10 of a run -> IDLE at k+11, result_valid never asserted, new x=3,y=3 then yields w=9.
REQ-038 SHALL cover: reset asserted mid-RUN together with kill and start_valid -> outputs per REQ-026 next cycle.
